// File: rtl/fetch_stage_pkg.sv
// Shared types for the rv32i fetch front end: FSM encoding and queue entry layout.
package fetch_stage_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE  = 2'd0;
  localparam fetch_state_t REQ   = 2'd1;
  localparam fetch_state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/fetch_stage_queue.sv
// Synchronous FIFO of fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q, count_q, count_d;
  logic         do_pop;

  assign do_pop     = pop && (count_q != '0);
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !do_pop) count_d = count_q + ONE;
    else if (!push && do_pop) count_d = count_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= push_data;
        wptr_q                <= wptr_q + ONE;
      end
      if (do_pop) rptr_q <= rptr_q + ONE;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch FSM: one outstanding word read, slot-reserved queue toward decode,
// redirect flush with in-flight response discard.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  output logic [3:0]  imem_wmask,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        dec_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  stale_pc_q, stale_pc_d;
  logic         flush, push, pop;
  logic [AW:0]  count, pop_ext, cnt_pop, cnt_push_pop;
  fetch_entry_t head, push_data;

  assign pop          = if_valid && dec_ready;
  assign pop_ext      = {{AW{1'b0}}, pop};
  // Occupancy after this edge, with and without a push, used for slot reservation.
  assign cnt_pop      = count - pop_ext;
  assign cnt_push_pop = count + ONE - pop_ext;
  assign push_data    = '{pc: fetch_pc_q, instr: imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    flush      = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
          state_d    = REQ;
        end else if (cnt_pop < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
          if (imem_resp) begin
            state_d = REQ;
          end else begin
            stale_pc_d = fetch_pc_q;
            state_d    = DRAIN;
          end
        end else if (imem_resp) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (cnt_push_pop < DEPTH_C) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // The queue is already empty here; the flush only keeps redirect semantics uniform.
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = word_align(redirect_pc);
        end
        if (imem_resp) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      stale_pc_q <= word_align(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_pc_q <= stale_pc_d;
    end
  end

  assign imem_addr  = (state_q == DRAIN) ? stale_pc_q : fetch_pc_q;
  assign imem_rmask = (state_q == REQ || state_q == DRAIN) ? 4'b1111 : 4'b0000;
  assign imem_wmask = 4'b0000;
  assign imem_wdata = 32'h0;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (if_valid),
    .count      (count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule
